// File: rtl/btrain_rx_if.sv
// Snapshot bus between the B-train receiver and the DDS controller core.
//   sync    : one-cycle sync strobe from the timing system (receiver input)
//   b_field : signed field snapshot, held between strobes
//   b_ready : one-cycle strobe, new b_field valid
// master = receiver side, slave = consumer / timing side.
interface btrain_rx_if #(
  parameter int B_FIELD_W = 32
);
  logic                 sync;
  logic [B_FIELD_W-1:0] b_field;
  logic                 b_ready;

  modport master (input sync, output b_field, output b_ready);
  modport slave  (output sync, input b_field, input b_ready);
endinterface

// File: rtl/btrain_rx.sv
// B-train receiver. Qualifies asynchronous up/down/zero pulses, accumulates
// weighted increments into a saturating signed field value and publishes a
// snapshot on every sync strobe.
//   clk, rst      : clock, synchronous active-high reset
//   btrain_up/dn  : async pulses, +/- step per accepted pulse
//   btrain_zero   : async zero marker, loads preset
//   ena           : 1 = accumulate, 0 = freeze accumulator
//   step, preset  : per-pulse weight (unsigned), zero-marker load value
//   clr_ovf       : clears sticky ovf
//   bus           : sync in, b_field/b_ready out
//   ovf           : sticky saturation flag
//   glitch_cnt    : saturating count of rejected short pulses

// One input lane: synchroniser plus LOW/HIGH/DONE pulse qualifier.
module btrain_qual #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  output logic ev,
  output logic glitch
);
  localparam int CW = $clog2(MIN_PULSE + 1);
  typedef enum logic [1:0] {LOW, HIGH, DONE} st_t;

  st_t                    st;
  logic [SYNC_STAGES-1:0] sr;
  logic [SYNC_STAGES-1:0] vld_pipe;
  logic                   armed;
  logic [CW-1:0]          cnt;
  logic                   s, s_vld;

  assign s     = sr[SYNC_STAGES-1];
  assign s_vld = vld_pipe[SYNC_STAGES-1];

  // vld_pipe marks when the cleared synchroniser holds real samples again;
  // armed then requires a genuine low so a pulse held across reset is not
  // mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr       <= '0;
      vld_pipe <= '0;
      armed    <= 1'b0;
      st       <= LOW;
      cnt      <= '0;
      ev       <= 1'b0;
      glitch   <= 1'b0;
    end else begin
      sr       <= {sr[SYNC_STAGES-2:0], a};
      vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
      armed    <= armed | (s_vld & ~s);
      ev       <= 1'b0;
      glitch   <= 1'b0;
      case (st)
        LOW: if (s && armed) begin
          st  <= HIGH;
          cnt <= CW'(1);
        end
        HIGH: begin
          if (!s) begin
            st     <= LOW;
            glitch <= 1'b1;
          end else if (int'(cnt) + 1 >= MIN_PULSE) begin
            ev <= 1'b1;
            st <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    if (!s) st <= LOW;
        default: st <= LOW;
      endcase
    end
  end
endmodule

module btrain_rx #(
  parameter int B_FIELD_W   = 32,
  parameter int STEP_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 3,
  parameter int GLITCH_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btrain_up,
  input  logic                 btrain_dn,
  input  logic                 btrain_zero,
  input  logic                 ena,
  input  logic [STEP_W-1:0]    step,
  input  logic [B_FIELD_W-1:0] preset,
  input  logic                 clr_ovf,
  btrain_rx_if.master          bus,
  output logic                 ovf,
  output logic [GLITCH_W-1:0]  glitch_cnt
);
  localparam int W = B_FIELD_W;
  localparam logic signed [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] ACC_MIN = {1'b1, {(W-1){1'b0}}};

  // lane 0 = up, 1 = dn, 2 = zero
  logic [2:0] raw, ev, gl;
  assign raw = {btrain_zero, btrain_dn, btrain_up};

  btrain_qual #(.SYNC_STAGES(SYNC_STAGES), .MIN_PULSE(MIN_PULSE)) u_q [2:0] (
    .clk    (clk),
    .rst    (rst),
    .a      (raw),
    .ev     (ev),
    .glitch (gl)
  );

  logic ev_up, ev_dn, ev_zero;
  assign ev_up   = ev[0];
  assign ev_dn   = ev[1];
  assign ev_zero = ev[2];

  // One extra bit of headroom makes overflow a simple top-two-bit mismatch.
  logic signed [W-1:0] acc;
  logic signed [W:0]   sum, step_x;
  logic                upd, hi, lo, ovf_set;

  assign step_x = $signed({{(W+1-STEP_W){1'b0}}, step});
  assign upd    = ev_up ^ ev_dn;

  always_comb begin
    sum = {acc[W-1], acc};
    if (ev_up && !ev_dn)      sum = sum + step_x;
    else if (ev_dn && !ev_up) sum = sum - step_x;
  end

  assign hi      = (sum[W:W-1] == 2'b01);
  assign lo      = (sum[W:W-1] == 2'b10);
  assign ovf_set = !ev_zero && ena && upd && (hi || lo);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      if (ev_zero)          acc <= preset;
      else if (ena && upd)  acc <= hi ? ACC_MAX : lo ? ACC_MIN : sum[W-1:0];
      // a set in the same cycle as clr_ovf takes precedence
      ovf <= (ovf & ~clr_ovf) | ovf_set;
    end
  end

  // Snapshot takes acc before this cycle's update.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.b_field <= '0;
      bus.b_ready <= 1'b0;
    end else begin
      bus.b_ready <= bus.sync;
      if (bus.sync) bus.b_field <= acc;
    end
  end

  // Several lanes may glitch in one cycle; add them all, saturating.
  logic [1:0]        g_sum;
  logic [GLITCH_W:0] g_nxt;
  assign g_sum = 2'(gl[0]) + 2'(gl[1]) + 2'(gl[2]);
  assign g_nxt = {1'b0, glitch_cnt} + (GLITCH_W+1)'(g_sum);

  always_ff @(posedge clk) begin
    if (rst)             glitch_cnt <= '0;
    else if (g_nxt[GLITCH_W]) glitch_cnt <= '1;
    else                 glitch_cnt <= g_nxt[GLITCH_W-1:0];
  end
endmodule

// File: tb/tb_btrain_rx.sv
module tb_btrain_rx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        up = 1'b0, dn = 1'b0, zero = 1'b0;
  logic        ena = 1'b0, clr_ovf = 1'b0;
  logic [15:0] step = '0;
  logic [31:0] preset = '0;
  logic        ovf;
  logic [15:0] glitch_cnt;
  int          n_chk = 0, n_fail = 0;

  btrain_rx_if #(.B_FIELD_W(32)) bus ();

  btrain_rx dut (
    .clk         (clk),
    .rst         (rst),
    .btrain_up   (up),
    .btrain_dn   (dn),
    .btrain_zero (zero),
    .ena         (ena),
    .step        (step),
    .preset      (preset),
    .clr_ovf     (clr_ovf),
    .bus         (bus),
    .ovf         (ovf),
    .glitch_cnt  (glitch_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // m = {zero, dn, up}; held high for w cycles, then idle long enough to settle
  task automatic pulse(input logic [2:0] m, input int w);
    @(negedge clk);
    {zero, dn, up} = m;
    repeat (w) @(negedge clk);
    {zero, dn, up} = 3'b000;
    repeat (8) @(negedge clk);
  endtask

  task automatic snap(input string tag, input logic [31:0] exp);
    @(negedge clk);
    bus.sync = 1'b1;
    @(negedge clk);
    bus.sync = 1'b0;
    chk({tag, "_rdy"}, 32'(bus.b_ready), 32'd1);
    chk({tag, "_fld"}, bus.b_field, exp);
    @(negedge clk);
    chk({tag, "_rdy0"}, 32'(bus.b_ready), 32'd0);
  endtask

  initial begin
    bus.sync = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_field", bus.b_field, 32'd0);
    chk("rst_ready", 32'(bus.b_ready), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_glitch", 32'(glitch_cnt), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 5 x +100
    step = 16'd100; ena = 1'b1;
    for (int i = 0; i < 5; i++) pulse(3'b001, 10);
    snap("up5", 32'd500);
    chk("up5_ovf", 32'(ovf), 32'd0);

    // preset -1000, then 3 x -7
    preset = -32'sd1000;
    pulse(3'b100, 8);
    step = 16'd7;
    for (int i = 0; i < 3; i++) pulse(3'b010, 6);
    snap("dn3", -32'sd1021);
    chk("dn3_glitch", 32'(glitch_cnt), 32'd0);

    // widths 1,2,3: only the 3-cycle pulse counts
    preset = 32'd0; pulse(3'b100, 8);
    step = 16'd5;
    pulse(3'b001, 1);
    pulse(3'b001, 2);
    pulse(3'b001, 3);
    snap("minp", 32'd5);
    chk("minp_glitch", 32'(glitch_cnt), 32'd2);

    // positive saturation
    preset = 32'h7FFF_FF00; pulse(3'b100, 8);
    step = 16'h0200;
    pulse(3'b001, 10);
    chk("sat_ovf", 32'(ovf), 32'd1);
    snap("sat", 32'h7FFF_FFFF);
    // clr_ovf exactly in the cycle of the second saturating update
    @(negedge clk); up = 1'b1;
    repeat (5) @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    chk("ovf_setwins", 32'(ovf), 32'd1);
    repeat (4) @(negedge clk); up = 1'b0;
    repeat (8) @(negedge clk);
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);

    // up+dn cancel; zero beats up; ena=0 freezes
    preset = 32'd1234; pulse(3'b100, 8);
    step = 16'd10;
    pulse(3'b011, 4);
    snap("updn", 32'd1234);
    preset = 32'd777;
    pulse(3'b101, 4);
    snap("zup", 32'd777);
    ena = 1'b0;
    for (int i = 0; i < 4; i++) pulse(3'b001, 4);
    snap("frz", 32'd777);
    ena = 1'b1;

    // sync coincident with the update cycle sees the old value
    preset = 32'd40; pulse(3'b100, 8);
    @(negedge clk); up = 1'b1;
    repeat (5) @(negedge clk);
    bus.sync = 1'b1;
    @(negedge clk); bus.sync = 1'b0;
    chk("coin_rdy", 32'(bus.b_ready), 32'd1);
    chk("coin_fld", bus.b_field, 32'd40);
    repeat (4) @(negedge clk); up = 1'b0;
    repeat (8) @(negedge clk);
    snap("coin_nxt", 32'd50);

    // reset mid-pulse
    @(negedge clk); up = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("mrst_field", bus.b_field, 32'd0);
    chk("mrst_ready", 32'(bus.b_ready), 32'd0);
    chk("mrst_ovf", 32'(ovf), 32'd0);
    chk("mrst_glitch", 32'(glitch_cnt), 32'd0);
    repeat (10) @(negedge clk);
    up = 1'b0;
    repeat (8) @(negedge clk);
    snap("mrst_held", 32'd0);
    chk("mrst_glitch2", 32'(glitch_cnt), 32'd0);
    pulse(3'b001, 4);
    snap("mrst_new", 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
